// File: rtl/reg_file.sv
// reg_file: bank of 2**ADDR_WIDTH registers with a per-entry busy scoreboard.
// Two combinational read ports, one synchronous write port, one reserve port.
// Optional feature macro: REG_FILE_BYPASS_EN forwards same-cycle write data
// and busy state to a read port whose address matches the write address.
module reg_file #(
   parameter int                       BIT_WIDTH   = 32,
   parameter int                       ADDR_WIDTH  = 4,
   parameter logic [BIT_WIDTH-1:0]     RESET_VALUE = '0,
   localparam int                      NUM_REGS    = 2**ADDR_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en_write,
   input  logic [ADDR_WIDTH-1:0]       write_addr,
   input  logic [BIT_WIDTH-1:0]        data_in,
   input  logic                        en_reserve,
   input  logic [ADDR_WIDTH-1:0]       reserve_addr,
   input  logic [ADDR_WIDTH-1:0]       read_addr_a,
   input  logic [ADDR_WIDTH-1:0]       read_addr_b,
   output logic [BIT_WIDTH-1:0]        data_out_a,
   output logic [BIT_WIDTH-1:0]        data_out_b,
   output logic                        busy_a,
   output logic                        busy_b,
   output logic [NUM_REGS-1:0]         busy_mask
);

   logic [BIT_WIDTH-1:0] mem [NUM_REGS];
   logic [NUM_REGS-1:0]  busy;

   // Data storage: reset loads every entry, a write updates one entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else if (en_write) begin
         mem[write_addr] <= data_in;
      end
   end

   // Scoreboard: write retires the producer, reserve issues a new one.
   // Reserve is assigned last so it wins when both hit the same entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (en_write) begin
            busy[write_addr] <= 1'b0;
         end
         if (en_reserve) begin
            busy[reserve_addr] <= 1'b1;
         end
      end
   end

   // Read ports: stored state, optionally overridden by same-cycle forwarding.
   always_comb begin
      data_out_a = mem[read_addr_a];
      data_out_b = mem[read_addr_b];
      busy_a     = busy[read_addr_a];
      busy_b     = busy[read_addr_b];
`ifdef REG_FILE_BYPASS_EN
      if (!reset && en_write && (write_addr == read_addr_a)) begin
         data_out_a = data_in;
         busy_a     = en_reserve && (reserve_addr == write_addr);
      end
      if (!reset && en_write && (write_addr == read_addr_b)) begin
         data_out_b = data_in;
         busy_b     = en_reserve && (reserve_addr == write_addr);
      end
`endif
   end

   // The full mask always shows registered scoreboard state.
   assign busy_mask = busy;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file (default and
// RESET_VALUE=5 instances share all inputs).
module tb_reg_file;

   localparam int BW = 32;
   localparam int AW = 4;
   localparam int NR = 2**AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          en_write;
   logic [AW-1:0] write_addr;
   logic [BW-1:0] data_in;
   logic          en_reserve;
   logic [AW-1:0] reserve_addr;
   logic [AW-1:0] read_addr_a;
   logic [AW-1:0] read_addr_b;
   logic [BW-1:0] data_out_a, data_out_b;
   logic          busy_a, busy_b;
   logic [NR-1:0] busy_mask;
   logic [BW-1:0] data_out_a5, data_out_b5;
   logic          busy_a5, busy_b5;
   logic [NR-1:0] busy_mask5;

   int checks = 0;
   int errors = 0;
   logic bypass_on;

   reg_file #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .RESET_VALUE('0)) dut (
      .clk(clk), .reset(reset), .en_write(en_write), .write_addr(write_addr),
      .data_in(data_in), .en_reserve(en_reserve), .reserve_addr(reserve_addr),
      .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
      .data_out_a(data_out_a), .data_out_b(data_out_b),
      .busy_a(busy_a), .busy_b(busy_b), .busy_mask(busy_mask)
   );

   reg_file #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .RESET_VALUE(32'd5)) dut5 (
      .clk(clk), .reset(reset), .en_write(en_write), .write_addr(write_addr),
      .data_in(data_in), .en_reserve(en_reserve), .reserve_addr(reserve_addr),
      .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
      .data_out_a(data_out_a5), .data_out_b(data_out_b5),
      .busy_a(busy_a5), .busy_b(busy_b5), .busy_mask(busy_mask5)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) begin
         read_addr_a = AW'(i);
         read_addr_b = AW'(NR - 1 - i);
         #1;
         checks++;
         if (data_out_a !== 32'd0 || data_out_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_data r%0d: got a=%h b=%h expected 0", i, data_out_a, data_out_b);
         end
         checks++;
         if (data_out_a5 !== 32'd5 || data_out_b5 !== 32'd5) begin
            errors++;
            $display("FAIL reset_data5 r%0d: got a=%h b=%h expected 5", i, data_out_a5, data_out_b5);
         end
      end
      checks++;
      if (busy_mask !== '0 || busy_mask5 !== '0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got mask=%h mask5=%h a=%b b=%b expected 0", busy_mask, busy_mask5, busy_a, busy_b);
      end
      // Write presented during reset must be discarded.
      en_write = 1'b1; write_addr = 4'd7; data_in = 32'h1234;
      en_reserve = 1'b1; reserve_addr = 4'd7;
      tick();
      en_write = 1'b0; en_reserve = 1'b0;
      read_addr_a = 4'd7;
      #1;
      checks++;
      if (data_out_a !== 32'd0 || busy_mask !== '0) begin
         errors++;
         $display("FAIL reset_discard: got data=%h mask=%h expected 0/0", data_out_a, busy_mask);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      en_write = 1'b1; write_addr = 4'd3; data_in = 32'd9;
      tick();
      write_addr = 4'd4; data_in = 32'd7;
      tick();
      en_write = 1'b0; data_in = 32'd8;
      read_addr_a = 4'd3; read_addr_b = 4'd4;
      #1;
      checks++;
      if (data_out_a !== 32'd9 || data_out_b !== 32'd7) begin
         errors++;
         $display("FAIL write_read: got a=%0d b=%0d expected 9/7", data_out_a, data_out_b);
      end
      tick();
      tick();
      checks++;
      if (data_out_a !== 32'd9 || data_out_b !== 32'd7) begin
         errors++;
         $display("FAIL write_hold: got a=%0d b=%0d expected 9/7", data_out_a, data_out_b);
      end
      // Both ports on the same entry.
      read_addr_b = 4'd3;
      #1;
      checks++;
      if (data_out_b !== 32'd9 || data_out_b5 !== 32'd9) begin
         errors++;
         $display("FAIL same_entry: got b=%0d b5=%0d expected 9", data_out_b, data_out_b5);
      end
   endtask

   task automatic test_bypass();
      logic [BW-1:0] exp_pre;
      exp_pre = bypass_on ? 32'hA5 : 32'h0;
      read_addr_a = 4'd2; read_addr_b = 4'd4;
      en_write = 1'b1; write_addr = 4'd2; data_in = 32'hA5;
      #1;
      checks++;
      if (data_out_a !== exp_pre || data_out_b !== 32'd7) begin
         errors++;
         $display("FAIL bypass_pre: got a=%h b=%h expected %h/7", data_out_a, data_out_b, exp_pre);
      end
      tick();
      en_write = 1'b0;
      #1;
      checks++;
      if (data_out_a !== 32'hA5) begin
         errors++;
         $display("FAIL bypass_post: got a=%h expected a5", data_out_a);
      end
   endtask

   task automatic test_scoreboard();
      logic exp_busy;
      en_reserve = 1'b1; reserve_addr = 4'd5;
      tick();
      en_reserve = 1'b0;
      read_addr_a = 4'd5;
      #1;
      checks++;
      if (busy_mask !== 16'h0020 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL reserve: got mask=%h busy_a=%b expected 0020/1", busy_mask, busy_a);
      end
      en_write = 1'b1; write_addr = 4'd5; data_in = 32'd1;
      tick();
      en_write = 1'b0;
      #1;
      checks++;
      if (busy_mask !== 16'h0000 || busy_a !== 1'b0 || data_out_a !== 32'd1) begin
         errors++;
         $display("FAIL release: got mask=%h busy_a=%b data=%h expected 0000/0/1", busy_mask, busy_a, data_out_a);
      end
      en_write = 1'b1; write_addr = 4'd5; data_in = 32'h33;
      en_reserve = 1'b1; reserve_addr = 4'd5;
      #1;
      exp_busy = bypass_on ? 1'b1 : 1'b0;
      checks++;
      if (busy_a !== exp_busy || busy_mask !== 16'h0000) begin
         errors++;
         $display("FAIL same_addr_pre: got busy_a=%b mask=%h expected %b/0000", busy_a, busy_mask, exp_busy);
      end
      tick();
      en_write = 1'b0; en_reserve = 1'b0;
      #1;
      checks++;
      if (data_out_a !== 32'h33 || busy_a !== 1'b1 || busy_mask !== 16'h0020) begin
         errors++;
         $display("FAIL same_addr: got data=%h busy_a=%b mask=%h expected 33/1/0020", data_out_a, busy_a, busy_mask);
      end
   endtask

   task automatic test_independent();
      en_write = 1'b1; write_addr = 4'd5; data_in = 32'h55;
      tick();
      write_addr = 4'd6; data_in = 32'h66;
      en_reserve = 1'b1; reserve_addr = 4'd1;
      tick();
      en_write = 1'b0; en_reserve = 1'b0;
      read_addr_a = 4'd1; read_addr_b = 4'd6;
      #1;
      checks++;
      if (busy_mask !== 16'h0002 || data_out_b !== 32'h66 || busy_a !== 1'b1 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL independent: got mask=%h r6=%h busy_a=%b busy_b=%b expected 0002/66/1/0",
                  busy_mask, data_out_b, busy_a, busy_b);
      end
   endtask

   task automatic test_reset_mid();
      en_reserve = 1'b1; reserve_addr = 4'd3;
      tick();
      en_reserve = 1'b0;
      read_addr_a = 4'd3; read_addr_b = 4'd6;
      #1;
      checks++;
      if (busy_mask !== 16'h000A || data_out_a !== 32'd9) begin
         errors++;
         $display("FAIL pre_reset: got mask=%h r3=%h expected 000a/9", busy_mask, data_out_a);
      end
      en_write = 1'b1; write_addr = 4'd3; data_in = 32'hDEAD;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (data_out_a !== 32'd0 || data_out_b !== 32'd0 || busy_mask !== '0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got a=%h b=%h mask=%h busy_a=%b expected 0/0/0/0",
                  data_out_a, data_out_b, busy_mask, busy_a);
      end
      tick();
      checks++;
      if (data_out_a !== 32'd0 || data_out_a5 !== 32'd5 || busy_mask !== '0) begin
         errors++;
         $display("FAIL reset_held: got a=%h a5=%h mask=%h expected 0/5/0", data_out_a, data_out_a5, busy_mask);
      end
      reset = 1'b0;
      tick();
      en_write = 1'b0;
      #1;
      checks++;
      if (data_out_a !== 32'hDEAD || data_out_a5 !== 32'hDEAD) begin
         errors++;
         $display("FAIL first_write_after_reset: got a=%h a5=%h expected dead", data_out_a, data_out_a5);
      end
   endtask

   initial begin
`ifdef REG_FILE_BYPASS_EN
      bypass_on = 1'b1;
`else
      bypass_on = 1'b0;
`endif
      reset = 1'b0; en_write = 1'b0; write_addr = '0; data_in = '0;
      en_reserve = 1'b0; reserve_addr = '0; read_addr_a = '0; read_addr_b = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_independent();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

Parameterised multi-entry register file with a per-entry busy scoreboard, generalising the single-word enable-write register to a bank of `NUM_REGS` words. It has two combinational read ports, one synchronous write port and a reserve port. It sits in the decode/writeback path of the processor: decode reads operands and reserves the destination, and writeback writes the result and releases the reservation.

## Interface
- `BIT_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 4, address width; `NUM_REGS` = 2**ADDR_WIDTH entries
- `RESET_VALUE`, 0, value loaded into every entry on reset (truncated to BIT_WIDTH)

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `en_write`  in  1  write enable
- `write_addr`  in  ADDR_WIDTH  entry to write
- `data_in`  in  BIT_WIDTH  write data
- `en_reserve`  in  1  reserve enable (marks entry busy)
- `reserve_addr`  in  ADDR_WIDTH  entry to reserve
- `read_addr_a`, `read_addr_b`  in  ADDR_WIDTH  read port addresses
- `data_out_a`, `data_out_b`  out  BIT_WIDTH  read data
- `busy_a`, `busy_b`  out  1  busy bit of the entry addressed by each read port
- `busy_mask`  out  NUM_REGS  all busy bits; bit i = entry i

## Operation
- Storage: NUM_REGS x BIT_WIDTH words plus NUM_REGS busy flags.
- Write: on a rising edge with `en_write`=1, `mem[write_addr]` <= `data_in` and `busy[write_addr]` <= 0. With `en_write`=0, all words hold.
- Reserve: on a rising edge with `en_reserve`=1, `busy[reserve_addr]` <= 1.
- Write and reserve to the same address on the same edge: data is written and busy ends **1**, because reserve wins (a new producer is issued as the old one retires).
- Write and reserve to different addresses on the same edge: both take effect independently.
- Reads are combinational and fully independent. Both ports may address the same entry.
- `busy_a`/`busy_b`/`busy_mask` reflect registered busy state, subject to the bypass rule under Configuration.
- No entry is hardwired; entry 0 is an ordinary register.

## Timing
- Reset (async): while `reset`=1, every entry equals RESET_VALUE and every busy bit is 0.
  - Outputs reflect this without waiting for a clock edge: `data_out_*`=RESET_VALUE, `busy_*`=0, `busy_mask`=0.
  - Writes and reserves presented while reset is asserted are discarded.
  - Deassertion takes effect at the next rising edge. The first write is accepted on the first edge with `reset`=0.
- Write latency: 1 edge. Without bypass, the new value is visible on `data_out_*` after the edge.
- Reserve latency: 1 edge. The busy bit is visible after the edge.
- Read-to-output: combinational, zero cycles.
- Reset mid-operation: reset asserted between edges clears state immediately. Any in-flight write or reserve is lost.

## Configuration
- Macro `REG_FILE_BYPASS_EN`.
- Defined: when `en_write`=1 and `write_addr` equals a read address in the same cycle:
  - That port's `data_out` = `data_in` combinationally.
  - That port's `busy` = 0, unless `en_reserve`=1 with `reserve_addr` equal to the same address, in which case `busy` = 1.
  - `busy_mask` is never bypassed; it always shows registered state.
  - Bypass is gated off while `reset`=1.
- Undefined: no forwarding. Read ports show stored data and registered busy only.

## Test plan
- Reset: pulse `reset` with no clock edge, BIT_WIDTH=32, RESET_VALUE=0 -> all reads 0 and `busy_mask`=0 immediately. Repeat with RESET_VALUE=5 -> every read returns 5.
- Write/read: write 9 to r3, then 7 to r4 on consecutive edges, then read a=r3, b=r4 -> 9 and 7. Hold `en_write`=0 with `data_in`=8 for 2 edges -> r3 and r4 unchanged.
- Same-cycle read of write address: write 0xA5 to r2 while reading r2 (old value 0).
  - With the macro: `data_out_a`=0xA5 before the edge.
  - Without it: `data_out_a`=0 before the edge and 0xA5 after.
- Scoreboard: reserve r5 -> `busy_mask`=0x0020, `busy_a`=1 for read r5. Write r5=1 -> busy cleared. Reserve and write r5 on the same edge -> data updated, busy stays 1.
- Independent ops: reserve r1 and write r6 on the same edge -> `busy_mask`=0x0002, r6 holds written data.
- Async reset mid-operation: assert `reset` between edges with r3 busy and `en_write`=1 to r3 pending -> r3=RESET_VALUE and `busy_mask`=0 immediately. No write lands at the next edge while reset is held.
